// File: rtl/endec_job_scheduler.sv
// Job scheduler in front of the shared endec core: round-robin arbitration of encode/decode
// jobs, endec load/run sequencing, response hand-back, encoder state carry-over and a watchdog.
module endec_job_scheduler #(
  parameter int GP_W        = 21,
  parameter int STATE_W     = 6,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 i_enc_req_valid,
  output logic                 o_enc_req_ready,
  input  logic [127:0]         i_enc_frame,
  input  logic                 i_enc_first,
  input  logic                 i_dec_req_valid,
  output logic                 o_dec_req_ready,
  input  logic [383:0]         i_dec_frame,
  input  logic                 i_code_rate,
  input  logic [GP_W-1:0]      i_gen_poly_flat,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic                 o_rsp_is_dec,
  output logic                 o_rsp_timeout,
  output logic [383:0]         o_rsp_enc_data,
  output logic [127:0]         o_rsp_dec_data,
  output logic                 o_en,
  output logic                 o_code_rate,
  output logic [GP_W-1:0]      o_gen_poly_flat,
  output logic [127:0]         o_encoder_data_frame,
  output logic [383:0]         o_decoder_data_frame,
  output logic [STATE_W-1:0]   o_prv_encoder_state,
  input  logic [383:0]         i_encoder_data,
  input  logic                 i_encoder_done,
  input  logic [127:0]         i_decoder_data,
  input  logic                 i_decoder_done,
  output logic                 o_busy,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_RESP,
    ST_DRAIN
  } state_t;

  state_t             state_reg;
  logic               pref_dec_reg;
  logic               mode_dec_reg;
  logic [STATE_W-1:0] enc_state_reg;
  logic [WD_W-1:0]    wd_cnt_reg;
  logic               grant_enc;
  logic               grant_dec;
  logic               mode_done;
  logic               wd_expire;

  // Grants are held low while reset is asserted so every output reads zero during reset.
  always_comb begin
    grant_enc = 1'b0;
    grant_dec = 1'b0;
    if (rst && state_reg == ST_IDLE) begin
      if (i_enc_req_valid && i_dec_req_valid) begin
        grant_dec = pref_dec_reg;
        grant_enc = !pref_dec_reg;
      end else begin
        grant_enc = i_enc_req_valid;
        grant_dec = i_dec_req_valid;
      end
    end
  end

  assign o_enc_req_ready = grant_enc;
  assign o_dec_req_ready = grant_dec;
  assign o_busy          = (state_reg != ST_IDLE);
  assign mode_done       = mode_dec_reg ? i_decoder_done : i_encoder_done;
  assign wd_expire       = (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_reg            <= ST_IDLE;
      pref_dec_reg         <= 1'b0;
      mode_dec_reg         <= 1'b0;
      enc_state_reg        <= '0;
      wd_cnt_reg           <= '0;
      o_rsp_valid          <= 1'b0;
      o_rsp_is_dec         <= 1'b0;
      o_rsp_timeout        <= 1'b0;
      o_rsp_enc_data       <= '0;
      o_rsp_dec_data       <= '0;
      o_en                 <= 1'b0;
      o_code_rate          <= 1'b0;
      o_gen_poly_flat      <= '0;
      o_encoder_data_frame <= '0;
      o_decoder_data_frame <= '0;
      o_prv_encoder_state  <= '0;
      o_err_cnt            <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_enc || grant_dec) begin
            mode_dec_reg    <= grant_dec;
            pref_dec_reg    <= grant_enc;
            o_code_rate     <= i_code_rate;
            o_gen_poly_flat <= i_gen_poly_flat;
            if (grant_enc) begin
              o_encoder_data_frame <= i_enc_frame;
              o_prv_encoder_state  <= i_enc_first ? '0 : enc_state_reg;
            end else begin
              o_decoder_data_frame <= i_dec_frame;
              o_prv_encoder_state  <= '0;
            end
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          o_en       <= 1'b1;
          wd_cnt_reg <= '0;
          state_reg  <= ST_RUN;
        end
        ST_RUN: begin
          // A done coinciding with watchdog expiry is treated as success.
          if (mode_done) begin
            o_en           <= 1'b0;
            o_rsp_valid    <= 1'b1;
            o_rsp_is_dec   <= mode_dec_reg;
            o_rsp_timeout  <= 1'b0;
            o_rsp_enc_data <= mode_dec_reg ? '0 : i_encoder_data;
            o_rsp_dec_data <= mode_dec_reg ? i_decoder_data : '0;
            if (!mode_dec_reg) begin
              enc_state_reg <= o_encoder_data_frame[STATE_W-1:0];
            end
            state_reg <= ST_RESP;
          end else if (wd_expire) begin
            o_en           <= 1'b0;
            o_rsp_valid    <= 1'b1;
            o_rsp_is_dec   <= mode_dec_reg;
            o_rsp_timeout  <= 1'b1;
            o_rsp_enc_data <= '0;
            o_rsp_dec_data <= '0;
            if (o_err_cnt != '1) begin
              o_err_cnt <= o_err_cnt + 1'b1;
            end
            if (!mode_dec_reg) begin
              enc_state_reg <= '0;
            end
            state_reg <= ST_RESP;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state_reg   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Let the core drop its done flags before the next job can start.
          if (!i_encoder_done && !i_decoder_done) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_endec_job_scheduler.sv
// Randomized self-checking bench for endec_job_scheduler against a job-level reference model.
module tb_endec_job_scheduler;
  localparam int GP_W        = 21;
  localparam int STATE_W     = 6;
  localparam int TIMEOUT_CYC = 1024;
  localparam int ERR_CNT_W   = 8;

  logic                 sys_clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 i_enc_req_valid = 1'b0;
  logic                 o_enc_req_ready;
  logic [127:0]         i_enc_frame = '0;
  logic                 i_enc_first = 1'b0;
  logic                 i_dec_req_valid = 1'b0;
  logic                 o_dec_req_ready;
  logic [383:0]         i_dec_frame = '0;
  logic                 i_code_rate = 1'b0;
  logic [GP_W-1:0]      i_gen_poly_flat = '0;
  logic                 o_rsp_valid;
  logic                 i_rsp_ready = 1'b0;
  logic                 o_rsp_is_dec;
  logic                 o_rsp_timeout;
  logic [383:0]         o_rsp_enc_data;
  logic [127:0]         o_rsp_dec_data;
  logic                 o_en;
  logic                 o_code_rate;
  logic [GP_W-1:0]      o_gen_poly_flat;
  logic [127:0]         o_encoder_data_frame;
  logic [383:0]         o_decoder_data_frame;
  logic [STATE_W-1:0]   o_prv_encoder_state;
  logic [383:0]         i_encoder_data = '0;
  logic                 i_encoder_done = 1'b0;
  logic [127:0]         i_decoder_data = '0;
  logic                 i_decoder_done = 1'b0;
  logic                 o_busy;
  logic [ERR_CNT_W-1:0] o_err_cnt;

  always #5 sys_clk = ~sys_clk;

  endec_job_scheduler #(
    .GP_W(GP_W), .STATE_W(STATE_W), .TIMEOUT_CYC(TIMEOUT_CYC), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .i_enc_req_valid(i_enc_req_valid), .o_enc_req_ready(o_enc_req_ready),
    .i_enc_frame(i_enc_frame), .i_enc_first(i_enc_first),
    .i_dec_req_valid(i_dec_req_valid), .o_dec_req_ready(o_dec_req_ready),
    .i_dec_frame(i_dec_frame), .i_code_rate(i_code_rate), .i_gen_poly_flat(i_gen_poly_flat),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_is_dec(o_rsp_is_dec),
    .o_rsp_timeout(o_rsp_timeout), .o_rsp_enc_data(o_rsp_enc_data), .o_rsp_dec_data(o_rsp_dec_data),
    .o_en(o_en), .o_code_rate(o_code_rate), .o_gen_poly_flat(o_gen_poly_flat),
    .o_encoder_data_frame(o_encoder_data_frame), .o_decoder_data_frame(o_decoder_data_frame),
    .o_prv_encoder_state(o_prv_encoder_state),
    .i_encoder_data(i_encoder_data), .i_encoder_done(i_encoder_done),
    .i_decoder_data(i_decoder_data), .i_decoder_done(i_decoder_done),
    .o_busy(o_busy), .o_err_cnt(o_err_cnt)
  );

  int checks = 0;
  int errors = 0;
  int job_id = 0;

  // Reference model: who is preferred next, the carried encoder state, the timeout count.
  bit                 m_pref_dec;
  logic [STATE_W-1:0] m_state;
  int                 m_err;

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [383:0] rand384();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_pref_dec = 1'b0;
    m_state    = '0;
    m_err      = 0;
  endtask

  // One complete job from IDLE back to IDLE. lat < 0 means the core never answers.
  task automatic run_job(input bit ev, input bit dv, input bit first, input logic [127:0] ef,
                         input int lat, input int bp, input int hold);
    bit                 win_dec;
    bit                 to;
    logic [STATE_W-1:0] exp_prv;
    logic [383:0]       df;
    logic [383:0]       tmp;
    logic               cr;
    logic [GP_W-1:0]    gp;
    logic [383:0]       exp_enc;
    logic [127:0]       exp_dec;
    int                 n;
    int                 exp_n;

    df = rand384();
    cr = 1'($urandom);
    gp = GP_W'($urandom);
    i_enc_req_valid = ev;
    i_dec_req_valid = dv;
    i_enc_frame     = ef;
    i_enc_first     = first;
    i_dec_frame     = df;
    i_code_rate     = cr;
    i_gen_poly_flat = gp;
    win_dec = (ev && dv) ? m_pref_dec : dv;
    #1;
    check("enc_ready", 384'(o_enc_req_ready), 384'(!win_dec));
    check("dec_ready", 384'(o_dec_req_ready), 384'(win_dec));
    m_pref_dec = !win_dec;
    exp_prv = (win_dec || first) ? '0 : m_state;

    @(negedge sys_clk);  // LOAD
    i_enc_req_valid = 1'b0;
    i_dec_req_valid = 1'b0;
    i_enc_frame     = rand384()[127:0];
    i_dec_frame     = rand384();
    i_code_rate     = ~cr;
    i_gen_poly_flat = ~gp;
    check("load_busy", 384'(o_busy), 384'(1));
    check("load_en", 384'(o_en), 384'(0));
    check("prv_state", 384'(o_prv_encoder_state), 384'(exp_prv));
    check("code_rate", 384'(o_code_rate), 384'(cr));
    check("gen_poly", 384'(o_gen_poly_flat), 384'(gp));
    if (win_dec) check("dec_frame", o_decoder_data_frame, df);
    else         check("enc_frame", 384'(o_encoder_data_frame), 384'(ef));

    @(negedge sys_clk);  // first RUN cycle
    check("run_en", 384'(o_en), 384'(1));
    to      = (lat < 0);
    exp_n   = to ? TIMEOUT_CYC : lat + 1;
    exp_enc = '0;
    exp_dec = '0;
    n = 0;
    while (!o_rsp_valid && n < TIMEOUT_CYC + 8) begin
      i_encoder_data = rand384();
      tmp = rand384();
      i_decoder_data = tmp[127:0];
      if (win_dec) begin
        i_decoder_done = (n == lat);
        i_encoder_done = ($urandom_range(0, 3) == 0);
        if (n == lat) exp_dec = i_decoder_data;
      end else begin
        i_encoder_done = (n == lat);
        i_decoder_done = ($urandom_range(0, 3) == 0);
        if (n == lat) exp_enc = i_encoder_data;
      end
      @(negedge sys_clk);
      n++;
    end
    check("run_cycles", 384'(n), 384'(exp_n));

    if (to) begin
      if (m_err < (1 << ERR_CNT_W) - 1) m_err++;
      if (!win_dec) m_state = '0;
    end else if (!win_dec) begin
      m_state = ef[STATE_W-1:0];
    end

    // RESP
    i_encoder_done = win_dec ? 1'b0 : (hold > 0);
    i_decoder_done = win_dec ? (hold > 0) : 1'b0;
    check("rsp_valid", 384'(o_rsp_valid), 384'(1));
    check("rsp_is_dec", 384'(o_rsp_is_dec), 384'(win_dec));
    check("rsp_timeout", 384'(o_rsp_timeout), 384'(to));
    check("err_cnt", 384'(o_err_cnt), 384'(m_err));
    for (int b = 0; b < bp; b++) begin
      i_enc_req_valid = 1'b1;
      i_dec_req_valid = 1'b1;
      #1;
      check("bp_enc_ready", 384'(o_enc_req_ready), 384'(0));
      check("bp_dec_ready", 384'(o_dec_req_ready), 384'(0));
      check("bp_en", 384'(o_en), 384'(0));
      check("bp_valid", 384'(o_rsp_valid), 384'(1));
      if (win_dec) check("bp_dec_data", 384'(o_rsp_dec_data), 384'(exp_dec));
      else         check("bp_enc_data", o_rsp_enc_data, exp_enc);
      @(negedge sys_clk);
    end
    i_enc_req_valid = 1'b0;
    i_dec_req_valid = 1'b0;
    if (win_dec) check("rsp_dec_data", 384'(o_rsp_dec_data), 384'(exp_dec));
    else         check("rsp_enc_data", o_rsp_enc_data, exp_enc);
    check("rsp_en", 384'(o_en), 384'(0));
    i_rsp_ready = 1'b1;
    @(negedge sys_clk);  // DRAIN
    i_rsp_ready = 1'b0;
    check("drain_valid", 384'(o_rsp_valid), 384'(0));
    check("drain_busy", 384'(o_busy), 384'(1));
    for (int j = 0; j < hold; j++) begin
      @(negedge sys_clk);
      check("drain_hold", 384'(o_busy), 384'(1));
    end
    i_encoder_done = 1'b0;
    i_decoder_done = 1'b0;
    @(negedge sys_clk);
    check("idle_busy", 384'(o_busy), 384'(0));
    $display("job %0d src=%s run_cycles=%0d timeout=%0d prv=%0h err_cnt=%0d",
             job_id, win_dec ? "DEC" : "ENC", n, to, exp_prv, m_err);
    job_id++;
  endtask

  initial begin
    logic [127:0] f;
    model_reset();
    i_enc_req_valid = 1'b1;
    i_dec_req_valid = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rst_enc_ready", 384'(o_enc_req_ready), 384'(0));
    check("rst_dec_ready", 384'(o_dec_req_ready), 384'(0));
    check("rst_busy", 384'(o_busy), 384'(0));
    check("rst_en", 384'(o_en), 384'(0));
    check("rst_rsp_valid", 384'(o_rsp_valid), 384'(0));
    check("rst_err_cnt", 384'(o_err_cnt), 384'(0));
    i_enc_req_valid = 1'b0;
    i_dec_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge sys_clk);

    // Both offered after reset: encode first, then alternation.
    run_job(1, 1, 1, {16{8'hA5}}, 3, 0, 0);
    run_job(1, 1, 0, rand384()[127:0], 2, 0, 0);
    f = rand384()[127:0];
    f[STATE_W-1:0] = 6'h2B;
    run_job(1, 1, 1, f, 4, 1, 1);
    run_job(1, 0, 0, rand384()[127:0], 1, 0, 0);   // expects carried state 2B
    // Watchdog: abort, then a done on the very last cycle wins.
    run_job(0, 1, 0, rand384()[127:0], -1, 0, 0);
    run_job(0, 1, 0, rand384()[127:0], TIMEOUT_CYC - 1, 0, 0);
    run_job(1, 0, 0, rand384()[127:0], -1, 0, 0);
    run_job(1, 0, 0, rand384()[127:0], 0, 0, 0);   // state cleared by the aborted encode
    // Long response backpressure.
    run_job(0, 1, 0, rand384()[127:0], 5, 50, 1);

    for (int k = 0; k < 40; k++) begin
      bit ev;
      bit dv;
      int sel;
      int lat;
      sel = $urandom_range(0, 2);
      ev  = (sel != 1);
      dv  = (sel != 0);
      lat = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 12);
      run_job(ev, dv, ($urandom_range(0, 3) == 0), rand384()[127:0], lat,
              $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset in the middle of a run.
    i_enc_req_valid = 1'b1;
    i_enc_first     = 1'b0;
    i_enc_frame     = rand384()[127:0];
    @(negedge sys_clk);
    i_enc_req_valid = 1'b0;
    @(negedge sys_clk);
    check("mid_run_en", 384'(o_en), 384'(1));
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check("mid_rst_en", 384'(o_en), 384'(0));
    check("mid_rst_busy", 384'(o_busy), 384'(0));
    check("mid_rst_valid", 384'(o_rsp_valid), 384'(0));
    check("mid_rst_err", 384'(o_err_cnt), 384'(0));
    check("mid_rst_prv", 384'(o_prv_encoder_state), 384'(0));
    @(negedge sys_clk);
    rst = 1'b1;
    model_reset();
    @(negedge sys_clk);
    run_job(1, 1, 0, rand384()[127:0], 2, 0, 0);
    run_job(1, 1, 0, rand384()[127:0], 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
